// File: rtl/stopwatch_ctrl_pkg.sv
// Shared types, digit limits and BCD helpers for the stopwatch controller.
// State encoding is fixed so the debug state can be decoded by external checkers.
package stopwatch_ctrl_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_PAUSE = 2'd2,
    ST_LAP   = 2'd3
  } sw_state_t;

  localparam logic [3:0] DIGIT_MAX     = 4'd9;
  localparam logic [3:0] SEC_TENS_MAX  = 4'd5;
  localparam int         DEB_TICKS_DEF = 20;

  // True when a two-digit BCD value sits at its last legal value.
  function automatic logic bcd_wrap(input logic [7:0] v, input logic [3:0] tens_max);
    return v == {tens_max, DIGIT_MAX};
  endfunction

  // Two-digit BCD increment that wraps to 00 after {tens_max, 9}.
  function automatic logic [7:0] bcd_inc(input logic [7:0] v, input logic [3:0] tens_max);
    logic [3:0] tens;
    logic [3:0] units;
    tens  = v[7:4];
    units = v[3:0] + 4'd1;
    if (v[3:0] == DIGIT_MAX) begin
      units = 4'd0;
      tens  = (v[7:4] == tens_max) ? 4'd0 : v[7:4] + 4'd1;
    end
    return {tens, units};
  endfunction

  function automatic logic [7:0] to_bcd(input int v);
    return {4'(v / 10), 4'(v % 10)};
  endfunction

endpackage

// File: rtl/stopwatch_ctrl_if.sv
// Display/status bundle from the stopwatch controller to the seven-segment scanner.
// The controller drives every signal (master); consumers only observe (slave).
interface stopwatch_ctrl_if;
  import stopwatch_ctrl_pkg::*;

  logic       running;
  logic       lap_hold;
  logic       overflow;
  logic [7:0] disp_min;
  logic [7:0] disp_sec;
  logic [7:0] disp_cs;
  sw_state_t  state;

  modport master (
    output running, lap_hold, overflow, disp_min, disp_sec, disp_cs, state
  );

  modport slave (
    input running, lap_hold, overflow, disp_min, disp_sec, disp_cs, state
  );
endinterface

// File: rtl/stopwatch_ctrl_key_debounce.sv
// One push key: synchronise, sample on each 1 kHz tick, accept a level after
// DEB_TICKS consecutive differing samples, pulse press on an accepted press.
module key_debounce
  import stopwatch_ctrl_pkg::*;
#(
  parameter int DEB_TICKS = DEB_TICKS_DEF
) (
  input  logic clk_50mhz,
  input  logic rst,
  input  logic tick_1k,
  input  logic key_n,
  output logic press
);

  localparam int             CW   = $clog2(DEB_TICKS + 1);
  localparam logic [CW-1:0] LAST = CW'(DEB_TICKS - 1);

  logic [1:0]    sync;
  logic          level;
  logic [CW-1:0] cnt;

  // Synchroniser and accepted level come out of reset at the released (high) level.
  always_ff @(posedge clk_50mhz) begin
    if (!rst) begin
      sync  <= 2'b11;
      level <= 1'b1;
      cnt   <= '0;
      press <= 1'b0;
    end else begin
      sync  <= {sync[0], key_n};
      press <= 1'b0;
      if (tick_1k) begin
        if (sync[1] == level) begin
          cnt <= '0;
        end else if (cnt == LAST) begin
          level <= sync[1];
          cnt   <= '0;
          press <= ~sync[1];
        end else begin
          cnt <= cnt + CW'(1);
        end
      end
    end
  end

endmodule

// File: rtl/stopwatch_ctrl.sv
// Stopwatch controller: divider edge detection, three debounced keys,
// IDLE/RUN/PAUSE/LAP sequencing and a saturating BCD mm:ss.cc count.
module stopwatch_ctrl
  import stopwatch_ctrl_pkg::*;
#(
  parameter int DEB_TICKS = DEB_TICKS_DEF,
  parameter int MAX_MIN   = 59
) (
  input  logic             clk_50mhz,
  input  logic             rst,
  input  logic             clk_1khz,
  input  logic             clk_100hz,
  input  logic             key_ss_n,
  input  logic             key_lap_n,
  input  logic             key_clr_n,
  stopwatch_ctrl_if.master disp
);

  localparam logic [7:0] MAX_MIN_BCD = to_bcd(MAX_MIN);

  logic [2:0] khz_sr, chz_sr;
  logic       tick_1k, tick_cs;
  logic       p_ss, p_lap, p_clr, go_ss, go_lap, go_clr;
  sw_state_t  state_q, state_d;
  logic       clear, latch_hold, count_en, at_max;
  logic [7:0] cnt_min, cnt_sec, cnt_cs, min_d, sec_d, cs_d;
  logic [7:0] hold_min, hold_sec, hold_cs;
  logic       ovf_q, ovf_d;
  logic       running_q, running_d, lap_q, lap_d;
  logic [7:0] dmin_q, dsec_q, dcs_q, dmin_d, dsec_d, dcs_d;

  // Divider outputs are data: {prev, sync2, sync1}, rising edge -> 1-cycle tick.
  always_ff @(posedge clk_50mhz) begin
    if (!rst) begin
      khz_sr <= '0;
      chz_sr <= '0;
    end else begin
      khz_sr <= {khz_sr[1:0], clk_1khz};
      chz_sr <= {chz_sr[1:0], clk_100hz};
    end
  end

  assign tick_1k = khz_sr[1] & ~khz_sr[2];
  assign tick_cs = chz_sr[1] & ~chz_sr[2];

  key_debounce #(.DEB_TICKS(DEB_TICKS)) u_deb_ss (
    .clk_50mhz(clk_50mhz), .rst(rst), .tick_1k(tick_1k), .key_n(key_ss_n), .press(p_ss));
  key_debounce #(.DEB_TICKS(DEB_TICKS)) u_deb_lap (
    .clk_50mhz(clk_50mhz), .rst(rst), .tick_1k(tick_1k), .key_n(key_lap_n), .press(p_lap));
  key_debounce #(.DEB_TICKS(DEB_TICKS)) u_deb_clr (
    .clk_50mhz(clk_50mhz), .rst(rst), .tick_1k(tick_1k), .key_n(key_clr_n), .press(p_clr));

  // Coincident presses: only the highest-priority one survives, even if it is ignored.
  assign go_clr = p_clr;
  assign go_ss  = p_ss & ~p_clr;
  assign go_lap = p_lap & ~p_ss & ~p_clr;

  always_ff @(posedge clk_50mhz) begin
    if (!rst) begin
      state_q   <= ST_IDLE;
      cnt_min   <= '0;
      cnt_sec   <= '0;
      cnt_cs    <= '0;
      hold_min  <= '0;
      hold_sec  <= '0;
      hold_cs   <= '0;
      ovf_q     <= 1'b0;
      running_q <= 1'b0;
      lap_q     <= 1'b0;
      dmin_q    <= '0;
      dsec_q    <= '0;
      dcs_q     <= '0;
    end else begin
      state_q   <= state_d;
      cnt_min   <= min_d;
      cnt_sec   <= sec_d;
      cnt_cs    <= cs_d;
      ovf_q     <= ovf_d;
      running_q <= running_d;
      lap_q     <= lap_d;
      dmin_q    <= dmin_d;
      dsec_q    <= dsec_d;
      dcs_q     <= dcs_d;
      if (latch_hold) begin
        hold_min <= cnt_min;
        hold_sec <= cnt_sec;
        hold_cs  <= cnt_cs;
      end
    end
  end

  // A set overflow flag forces PAUSE one cycle after saturation.
  always_comb begin
    state_d    = state_q;
    clear      = 1'b0;
    latch_hold = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (go_ss) state_d = ST_RUN;
        else if (go_clr) clear = 1'b1;
      end
      ST_RUN: begin
        if (ovf_q || go_ss) state_d = ST_PAUSE;
        else if (go_lap) begin
          state_d    = ST_LAP;
          latch_hold = 1'b1;
        end
      end
      ST_LAP: begin
        if (ovf_q || go_ss) state_d = ST_PAUSE;
        else if (go_lap) state_d = ST_RUN;
      end
      ST_PAUSE: begin
        if (go_clr) begin
          state_d = ST_IDLE;
          clear   = 1'b1;
        end else if (go_ss && !ovf_q) begin
          state_d = ST_RUN;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  assign count_en = tick_cs && (state_q == ST_RUN || state_q == ST_LAP);
  assign at_max   = (cnt_min == MAX_MIN_BCD) && bcd_wrap(cnt_sec, SEC_TENS_MAX)
                    && bcd_wrap(cnt_cs, DIGIT_MAX);

  always_comb begin
    min_d = cnt_min;
    sec_d = cnt_sec;
    cs_d  = cnt_cs;
    ovf_d = ovf_q;
    if (clear) begin
      min_d = '0;
      sec_d = '0;
      cs_d  = '0;
      ovf_d = 1'b0;
    end else if (count_en) begin
      if (at_max) begin
        ovf_d = 1'b1;
      end else begin
        cs_d = bcd_inc(cnt_cs, DIGIT_MAX);
        if (bcd_wrap(cnt_cs, DIGIT_MAX)) begin
          sec_d = bcd_inc(cnt_sec, SEC_TENS_MAX);
          if (bcd_wrap(cnt_sec, SEC_TENS_MAX)) min_d = bcd_inc(cnt_min, DIGIT_MAX);
        end
      end
    end
  end

  always_comb begin
    running_d = (state_q == ST_RUN) || (state_q == ST_LAP);
    lap_d     = (state_q == ST_LAP);
    dmin_d    = lap_d ? hold_min : cnt_min;
    dsec_d    = lap_d ? hold_sec : cnt_sec;
    dcs_d     = lap_d ? hold_cs  : cnt_cs;
  end

  assign disp.running  = running_q;
  assign disp.lap_hold = lap_q;
  assign disp.overflow = ovf_q;
  assign disp.disp_min = dmin_q;
  assign disp.disp_sec = dsec_q;
  assign disp.disp_cs  = dcs_q;
  assign disp.state    = state_q;

endmodule

// File: tb/tb_stopwatch_ctrl.sv
// Directed bench for stopwatch_ctrl with DEB_TICKS=2: a table of key/tick steps
// with hand-computed displays, then preload, saturation and reset sequences.
module tb_stopwatch_ctrl;
  import stopwatch_ctrl_pkg::*;

  logic clk_50mhz = 1'b0;
  logic rst       = 1'b0;
  logic clk_1khz  = 1'b0;
  logic clk_100hz = 1'b0;
  logic key_ss_n  = 1'b1;
  logic key_lap_n = 1'b1;
  logic key_clr_n = 1'b1;
  logic [2:0] ph  = 3'd0;
  logic [7:0] pm, ps, pc;
  int total = 0;
  int bad   = 0;

  typedef struct {
    logic [2:0]  keys;   // {clr, lap, ss}
    int          lows;   // 1 kHz samples the keys are held low
    int          ticks;  // centisecond ticks after the keys
    logic        run;
    logic        lap;
    logic        ovf;
    logic [23:0] d;      // expected mm ss cc
  } vec_t;

  vec_t vecs[14];

  stopwatch_ctrl_if sw_if ();

  stopwatch_ctrl #(.DEB_TICKS(2), .MAX_MIN(59)) dut (
    .clk_50mhz(clk_50mhz),
    .rst      (rst),
    .clk_1khz (clk_1khz),
    .clk_100hz(clk_100hz),
    .key_ss_n (key_ss_n),
    .key_lap_n(key_lap_n),
    .key_clr_n(key_clr_n),
    .disp     (sw_if)
  );

  // Clock/reset block: 50 MHz clock, 1 kHz input toggling every 4 cycles.
  initial forever #10 clk_50mhz = ~clk_50mhz;
  always @(posedge clk_50mhz) ph <= ph + 3'd1;
  always @(negedge clk_50mhz) clk_1khz = ph[2];

  function automatic logic [23:0] disp24();
    return {sw_if.disp_min, sw_if.disp_sec, sw_if.disp_cs};
  endfunction

  task automatic chk(input string name, input logic [23:0] act, input logic [23:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", name, act, exp);
    end
  endtask

  task automatic chk_outs(input string tag, input logic r, input logic l, input logic o,
                          input logic [23:0] d);
    chk({tag, " running"},  24'(sw_if.running),  24'(r));
    chk({tag, " lap_hold"}, 24'(sw_if.lap_hold), 24'(l));
    chk({tag, " overflow"}, 24'(sw_if.overflow), 24'(o));
    chk({tag, " disp"},     disp24(),            d);
  endtask

  task automatic chk_state(input string tag, input sw_state_t s);
    chk({tag, " state"}, 24'(sw_if.state), 24'(s));
  endtask

  task automatic align();
    @(negedge clk_50mhz);
    while (ph != 3'd0) @(negedge clk_50mhz);
  endtask

  // Driver: hold the masked keys low for a whole number of 1 kHz samples, then release.
  task automatic press_keys(input logic [2:0] m, input int lows);
    align();
    key_ss_n  = ~m[0];
    key_lap_n = ~m[1];
    key_clr_n = ~m[2];
    repeat (8 * lows) @(negedge clk_50mhz);
    key_ss_n  = 1'b1;
    key_lap_n = 1'b1;
    key_clr_n = 1'b1;
    repeat (32) @(negedge clk_50mhz);
  endtask

  task automatic cs_ticks(input int n);
    for (int i = 0; i < n; i++) begin
      clk_100hz = 1'b1;
      repeat (8) @(negedge clk_50mhz);
      clk_100hz = 1'b0;
      repeat (8) @(negedge clk_50mhz);
    end
  endtask

  task preload(input logic [7:0] m, input logic [7:0] s, input logic [7:0] c);
    pm = m;
    ps = s;
    pc = c;
    force dut.cnt_min = pm;
    force dut.cnt_sec = ps;
    force dut.cnt_cs  = pc;
    repeat (3) @(negedge clk_50mhz);
    release dut.cnt_min;
    release dut.cnt_sec;
    release dut.cnt_cs;
    repeat (3) @(negedge clk_50mhz);
  endtask

  initial begin
    vecs[0]  = '{3'b001, 3, 0,   1'b1, 1'b0, 1'b0, 24'h000000}; // ss: IDLE -> RUN
    vecs[1]  = '{3'b000, 0, 30,  1'b1, 1'b0, 1'b0, 24'h000030};
    vecs[2]  = '{3'b010, 3, 0,   1'b1, 1'b1, 1'b0, 24'h000030}; // lap latch
    vecs[3]  = '{3'b000, 0, 20,  1'b1, 1'b1, 1'b0, 24'h000030}; // frozen display
    vecs[4]  = '{3'b010, 3, 0,   1'b1, 1'b0, 1'b0, 24'h000050}; // back to live
    vecs[5]  = '{3'b000, 0, 100, 1'b1, 1'b0, 1'b0, 24'h000150}; // cs carry into sec
    vecs[6]  = '{3'b100, 3, 0,   1'b1, 1'b0, 1'b0, 24'h000150}; // clr ignored in RUN
    vecs[7]  = '{3'b000, 0, 5,   1'b1, 1'b0, 1'b0, 24'h000155};
    vecs[8]  = '{3'b001, 1, 0,   1'b1, 1'b0, 1'b0, 24'h000155}; // 1-sample glitch
    vecs[9]  = '{3'b001, 3, 0,   1'b0, 1'b0, 1'b0, 24'h000155}; // RUN -> PAUSE
    vecs[10] = '{3'b000, 0, 3,   1'b0, 1'b0, 1'b0, 24'h000155}; // no count in PAUSE
    vecs[11] = '{3'b101, 3, 0,   1'b0, 1'b0, 1'b0, 24'h000000}; // clr beats ss
    vecs[12] = '{3'b000, 0, 2,   1'b0, 1'b0, 1'b0, 24'h000000};
    vecs[13] = '{3'b010, 3, 0,   1'b0, 1'b0, 1'b0, 24'h000000}; // lap ignored in IDLE

    rst = 1'b0;
    repeat (10) @(negedge clk_50mhz);
    chk_outs("reset", 1'b0, 1'b0, 1'b0, 24'h000000);
    chk_state("reset", ST_IDLE);
    rst = 1'b1;
    repeat (4) @(negedge clk_50mhz);

    for (int i = 0; i < 14; i++) begin
      if (vecs[i].keys != 3'b000) press_keys(vecs[i].keys, vecs[i].lows);
      cs_ticks(vecs[i].ticks);
      chk_outs($sformatf("v%0d", i), vecs[i].run, vecs[i].lap, vecs[i].ovf, vecs[i].d);
    end
    chk_state("after table", ST_IDLE);

    // Minute carry from a preloaded 00:59.99.
    preload(8'h00, 8'h59, 8'h99);
    chk("preload disp", disp24(), 24'h005999);
    press_keys(3'b001, 3);
    chk_outs("carry start", 1'b1, 1'b0, 1'b0, 24'h005999);
    cs_ticks(1);
    chk("carry min", disp24(), 24'h010000);
    press_keys(3'b001, 3);
    press_keys(3'b100, 3);
    chk("carry clr", disp24(), 24'h000000);
    chk_state("carry clr", ST_IDLE);

    // Saturation at 59:59.99, ignored ss, then clr.
    preload(8'h59, 8'h59, 8'h98);
    press_keys(3'b001, 3);
    cs_ticks(2);
    chk_outs("sat", 1'b0, 1'b0, 1'b1, 24'h595999);
    chk_state("sat", ST_PAUSE);
    press_keys(3'b001, 3);
    cs_ticks(1);
    chk_outs("sat ss", 1'b0, 1'b0, 1'b1, 24'h595999);
    chk_state("sat ss", ST_PAUSE);
    press_keys(3'b100, 3);
    chk_outs("sat clr", 1'b0, 1'b0, 1'b0, 24'h000000);
    chk_state("sat clr", ST_IDLE);

    // Reset mid-RUN with the ss key half-debounced.
    press_keys(3'b001, 3);
    cs_ticks(7);
    chk_outs("pre rst", 1'b1, 1'b0, 1'b0, 24'h000007);
    align();
    key_ss_n = 1'b0;
    repeat (8) @(negedge clk_50mhz);
    rst = 1'b0;
    @(negedge clk_50mhz);
    chk_outs("mid rst", 1'b0, 1'b0, 1'b0, 24'h000000);
    chk_state("mid rst", ST_IDLE);
    repeat (7) @(negedge clk_50mhz);
    rst = 1'b1;
    repeat (8) @(negedge clk_50mhz);
    key_ss_n = 1'b1;
    repeat (40) @(negedge clk_50mhz);
    chk_state("post rst partial", ST_IDLE);
    chk("post rst running", 24'(sw_if.running), 24'(1'b0));
    press_keys(3'b001, 3);
    chk("post rst press", 24'(sw_if.running), 24'(1'b1));
    chk_state("post rst press", ST_RUN);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/stopwatch_ctrl.md
Name: stopwatch_ctrl

Overview:
- Stopwatch controller that sequences timekeeping from the frequency divider's 1 kHz and 100 Hz outputs, which it takes as data inputs, not as clocks.
- Debounces three push keys and runs an IDLE/RUN/PAUSE/LAP state machine.
- Maintains a BCD mm:ss.cc count and drives the display value to the seven-segment scanner.
- All logic runs in the clk_50mhz domain.

Parameters:
- DEB_TICKS, 20, consecutive 1 kHz samples a key must hold a level before the change is accepted (ms).
- MAX_MIN, 59, highest minute value (BCD-compared) before saturation.

Ports:
- clk_50mhz  in  1  system clock
- rst  in  1  synchronous, active-low reset
- clk_1khz  in  1  divider output, used only as a sampled signal
- clk_100hz  in  1  divider output, used only as a sampled signal
- key_ss_n  in  1  raw start/stop key, active-low
- key_lap_n  in  1  raw lap key, active-low
- key_clr_n  in  1  raw clear key, active-low
- running  out  1  high in RUN or LAP
- lap_hold  out  1  high in LAP
- overflow  out  1  sticky; set at saturation
- disp_min  out  8  BCD tens:units minutes
- disp_sec  out  8  BCD tens:units seconds
- disp_cs  out  8  BCD tens:units centiseconds

Behaviour:
- Reset (rst=0 at a clk_50mhz edge) is synchronous, active-low, with clock clk_50mhz. It is honoured in every state, including mid-count and mid-debounce.
  - All outputs go to 0 and the state goes to IDLE.
  - Debouncers go to the released state with their counters at 0.
  - Synchronizer flops are cleared.
- Tick generation: each divider input passes through 2 synchronizer flops plus 1 previous-value flop.
  - tick_1k / tick_cs is a 1-cycle pulse on each rising edge.
  - Each pulse asserts 3 clk_50mhz cycles after the input's rising edge.
- Debounce, per key, on each tick_1k:
  - A sample that differs from the accepted level increments the counter; a matching sample clears it.
  - When the counter reaches DEB_TICKS, the level is accepted and the counter clears.
  - A 1-cycle press pulse fires on an accepted high-to-low change only.
  - The key must be accepted as released before it can produce another press.
- Press priority when pulses coincide in one cycle: clr > ss > lap. Only the highest-priority press is acted on; the others are dropped.
- FSM transitions:
  - IDLE: ss -> RUN. clr -> IDLE, counters cleared. lap is ignored.
  - RUN: ss -> PAUSE. lap -> LAP, latching the live count into the display hold register. clr is ignored.
  - LAP: ss -> PAUSE, display returns to the live count. lap -> RUN, display returns to live. clr is ignored. The count keeps advancing.
  - PAUSE: ss -> RUN. clr -> IDLE, counters cleared and overflow cleared. lap is ignored.
- Counting occurs on tick_cs when the current state is RUN or LAP.
  - A state change in the same cycle does not suppress that increment.
  - Carry chain: cs units 9->0 carries to cs tens; cs 99->00 carries to sec; sec 59->00 carries to min.
- Saturation: a tick_cs at MAX_MIN:59.99 leaves the count unchanged and sets overflow=1. On the next cycle the FSM forces PAUSE (from RUN, or from LAP with display returned to live). ss in PAUSE with overflow=1 is ignored.
- Display outputs:
  - The hold register drives them while in LAP; otherwise the live count drives them.
  - Outputs are registered, with 1-cycle latency from a count or state change.
- No BCD digit ever exceeds 9. Sec tens never exceeds 5.

Decomposition:
- Shared package:
  - state encoding: IDLE=0, RUN=1, PAUSE=2, LAP=3
  - BCD digit limits (9, 5)
  - default DEB_TICKS
- Sub-module key_debounce (ports: clk_50mhz, rst, tick_1k, key_n, press), instantiated three times.
- Tick edge detectors stay inline.

Test Plan (DEB_TICKS=2; bench toggles clk_1khz and clk_100hz every 4 and 8 clk_50mhz cycles):
- Reset, then hold key_ss_n low for 3 ms-ticks -> exactly one press; running=1 from the following cycle. A 1-tick glitch produces no press.
- RUN for 150 tick_cs -> disp shows 00:01.50 with BCD carry. Preload 00:59.99, then 1 tick -> 01:00.00.
- In RUN, lap press at 00:00.30 -> lap_hold=1 and display frozen at 00:00.30 while live advances. Second lap press after 20 ticks -> display 00:00.50.
- Same-cycle clr+ss presses in PAUSE -> IDLE, all digits 00, running=0. clr in RUN -> ignored, count continues.
- Preload 59:59.98, 2 tick_cs -> display 59:59.99, overflow=1, state PAUSE. ss then ignored; clr -> overflow=0, 00:00.00.
- Assert rst low mid-RUN with a key half-debounced -> all outputs 0 next cycle; first press after release needs the full DEB_TICKS.
